// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter
//   Shares one single-port block RAM between two requesters (A and B).
//   Each requester issues single-word reads or writes over a req/ack
//   handshake; transactions are serialized one at a time and granted
//   round-robin.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata   requester A transaction (held until a_ack)
//   a_ack, a_rdata              A completion pulse and read data
//   b_*                         same set for requester B
//   mem_add/mem_write/mem_read/mem_din   registered drive of the RAM pins
//   mem_dout                    RAM read data (valid RD_LAT cycles after read)
//   busy                        high while a transaction is in progress
module bram_port_arbiter #(
   parameter int AW     = 10,
   parameter int DW     = 16,
   parameter int RD_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          a_req,
   input  logic          a_we,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_wdata,
   output logic          a_ack,
   output logic [DW-1:0] a_rdata,
   input  logic          b_req,
   input  logic          b_we,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_wdata,
   output logic          b_ack,
   output logic [DW-1:0] b_rdata,
   output logic [AW-1:0] mem_add,
   output logic          mem_write,
   output logic          mem_read,
   output logic [DW-1:0] mem_din,
   input  logic [DW-1:0] mem_dout,
   output logic          busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

   localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);

   state_t        state_q, state_d;
   logic          ptr_q, ptr_d;          // 0: A has priority, 1: B has priority
   logic          win_q, win_d;          // requester being served (0 = A)
   logic          we_q, we_d;
   logic          mask_q, mask_d;        // high in the IDLE cycle right after ACK
   logic [1:0]    cnt_q, cnt_d;
   logic [AW-1:0] add_q, add_d;
   logic [DW-1:0] din_q, din_d;
   logic          wr_q, wr_d;
   logic          rd_q, rd_d;
   logic          busy_q, busy_d;

   logic [1:0]    req_v, we_v, elig_v;
   logic [AW-1:0] addr_v  [2];
   logic [DW-1:0] wdata_v [2];
   logic          grant_b;
   logic          capture;

   assign req_v      = {b_req, a_req};
   assign we_v       = {b_we, a_we};
   assign addr_v[0]  = a_addr;
   assign addr_v[1]  = b_addr;
   assign wdata_v[0] = a_wdata;
   assign wdata_v[1] = b_wdata;

   // A lone eligible request wins outright; on a collision the pointer decides.
   assign grant_b = elig_v[1] & (~elig_v[0] | ptr_q);

   // Last WAIT cycle: mem_dout is valid now and is latched at this edge.
   assign capture = (state_q == WAIT) && (cnt_q == 2'd0);

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_port
         logic          ack_q, ack_d;
         logic [DW-1:0] rdata_q, rdata_d;

         // The requester just served is ignored for one cycle so that its
         // dropping req is not mistaken for a new request.
         assign elig_v[gi] = req_v[gi] & ~(mask_q & (win_q == 1'(gi)));

         always_comb begin
            ack_d   = 1'b0;
            rdata_d = rdata_q;
            if (win_q == 1'(gi)) begin
               ack_d = (state_d == ACK);
               if (capture) begin
                  rdata_d = mem_dout;
               end
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               ack_q   <= 1'b0;
               rdata_q <= '0;
            end else begin
               ack_q   <= ack_d;
               rdata_q <= rdata_d;
            end
         end
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      win_d   = win_q;
      we_d    = we_q;
      mask_d  = 1'b0;
      cnt_d   = cnt_q;
      add_d   = add_q;
      din_d   = din_q;
      wr_d    = 1'b0;
      rd_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (|elig_v) begin
               win_d   = grant_b;
               we_d    = we_v[grant_b];
               add_d   = addr_v[grant_b];
               din_d   = wdata_v[grant_b];
               wr_d    = we_v[grant_b];
               rd_d    = ~we_v[grant_b];
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (we_q) begin
               state_d = ACK;
            end else begin
               cnt_d   = LAT_M1;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == 2'd0) begin
               state_d = ACK;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         ACK: begin
            ptr_d   = ~win_q;
            mask_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= 1'b0;
         win_q   <= 1'b0;
         we_q    <= 1'b0;
         mask_q  <= 1'b0;
         cnt_q   <= 2'd0;
         add_q   <= '0;
         din_q   <= '0;
         wr_q    <= 1'b0;
         rd_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
         we_q    <= we_d;
         mask_q  <= mask_d;
         cnt_q   <= cnt_d;
         add_q   <= add_d;
         din_q   <= din_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         busy_q  <= busy_d;
      end
   end

   assign a_ack     = g_port[0].ack_q;
   assign a_rdata   = g_port[0].rdata_q;
   assign b_ack     = g_port[1].ack_q;
   assign b_rdata   = g_port[1].rdata_q;
   assign mem_add   = add_q;
   assign mem_din   = din_q;
   assign mem_write = wr_q;
   assign mem_read  = rd_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: directed transactions through two requester
// agents, a scoreboard of expected grants/data, and a second instance with
// a 3-cycle RAM latency.
module tb_bram_port_arbiter;

   localparam int LAT1 = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        a_req, a_we, b_req, b_we;
   logic [9:0]  a_addr, b_addr;
   logic [15:0] a_wdata, b_wdata;
   logic        a_ack, b_ack, mem_write, mem_read, busy;
   logic [15:0] a_rdata, b_rdata, mem_din, mem_dout;
   logic [9:0]  mem_add;

   bram_port_arbiter #(.AW(10), .DW(16), .RD_LAT(LAT1)) u_dut (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ack(a_ack), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ack(b_ack), .b_rdata(b_rdata),
      .mem_add(mem_add), .mem_write(mem_write), .mem_read(mem_read),
      .mem_din(mem_din), .mem_dout(mem_dout), .busy(busy)
   );

   // RAM model, 1-cycle registered read; dout is only valid in the cycle
   // after a read strobe so a mistimed capture shows up as 16'hDEAD.
   logic [15:0] mem1 [0:1023];
   always @(posedge clk) begin
      if (mem_write) mem1[mem_add] <= mem_din;
      mem_dout <= mem_read ? mem1[mem_add] : 16'hDEAD;
   end

   // Second instance with RD_LAT = 3, requester A only.
   logic        r3_a_req, r3_a_we, r3_b_req, r3_b_we;
   logic [9:0]  r3_a_addr, r3_b_addr, r3_mem_add;
   logic [15:0] r3_a_wdata, r3_b_wdata, r3_a_rdata, r3_b_rdata;
   logic [15:0] r3_mem_din, r3_mem_dout, r3_p1, r3_p2;
   logic        r3_a_ack, r3_b_ack, r3_mem_write, r3_mem_read, r3_busy;

   bram_port_arbiter #(.AW(10), .DW(16), .RD_LAT(3)) u_dut3 (
      .clk(clk), .rst(rst),
      .a_req(r3_a_req), .a_we(r3_a_we), .a_addr(r3_a_addr), .a_wdata(r3_a_wdata),
      .a_ack(r3_a_ack), .a_rdata(r3_a_rdata),
      .b_req(r3_b_req), .b_we(r3_b_we), .b_addr(r3_b_addr), .b_wdata(r3_b_wdata),
      .b_ack(r3_b_ack), .b_rdata(r3_b_rdata),
      .mem_add(r3_mem_add), .mem_write(r3_mem_write), .mem_read(r3_mem_read),
      .mem_din(r3_mem_din), .mem_dout(r3_mem_dout), .busy(r3_busy)
   );

   logic [15:0] mem3 [0:1023];
   always @(posedge clk) begin
      if (r3_mem_write) mem3[r3_mem_add] <= r3_mem_din;
      r3_p1       <= r3_mem_read ? mem3[r3_mem_add] : 16'hDEAD;
      r3_p2       <= r3_p1;
      r3_mem_dout <= r3_p2;
   end

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic        who;    // 0 = A, 1 = B
      logic        we;
      logic [9:0]  addr;
      logic [15:0] wdata;
      logic [15:0] rdata;  // expected read data (reads only)
   } txn_t;

   txn_t        sb[$];
   txn_t        a_cmds[$];
   txn_t        b_cmds[$];
   int unsigned strobe_log[$];
   int unsigned ack_log[$];
   int unsigned last_strobe = 0;
   int unsigned a_elig = 0, b_elig = 0;
   logic [15:0] a_prev = '0, b_prev = '0;
   int          n_checks = 0, n_errors = 0;

   function automatic txn_t mk(input logic who, input logic we, input logic [9:0] addr,
                               input logic [15:0] wd, input logic [15:0] rd);
      txn_t t;
      t.who = who; t.we = we; t.addr = addr; t.wdata = wd; t.rdata = rd;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: checks strobes against the head of the scoreboard and pops it
   // on every ack.
   always @(posedge clk) begin : mon
      txn_t t;
      #1;
      if (rst) begin
         sb.delete();
         a_prev = '0;
         b_prev = '0;
         chk("rst_zero", 32'({a_ack, b_ack, mem_write, mem_read, busy,
                              |mem_add, |mem_din, |a_rdata, |b_rdata}), 32'd0);
      end else begin
         if (mem_write || mem_read) begin
            chk("strobe_excl", 32'(mem_write & mem_read), 32'd0);
            if (sb.size() == 0) begin
               n_checks++; n_errors++;
               $display("FAIL strobe_unexpected actual=strobe required=none (cycle %0d)", cyc);
            end else begin
               t = sb[0];
               chk("strobe_kind", 32'(mem_write), 32'(t.we));
               chk("strobe_addr", 32'(mem_add), 32'(t.addr));
               if (t.we) chk("strobe_din", 32'(mem_din), 32'(t.wdata));
               chk("strobe_busy", 32'(busy), 32'd1);
            end
            last_strobe = cyc;
            strobe_log.push_back(cyc);
         end
         if (a_ack || b_ack) begin
            chk("ack_excl", 32'(a_ack & b_ack), 32'd0);
            if (sb.size() == 0) begin
               n_checks++; n_errors++;
               $display("FAIL ack_unexpected actual=ack(a=%0d b=%0d) required=none (cycle %0d)",
                        a_ack, b_ack, cyc);
            end else begin
               t = sb.pop_front();
               chk("ack_who", 32'(b_ack), 32'(t.who));
               chk("ack_latency", cyc - last_strobe, 32'(t.we ? 1 : 1 + LAT1));
               chk("ack_busy", 32'(busy), 32'd1);
               if (!t.who) begin
                  if (!t.we) a_prev = t.rdata;
                  chk("a_rdata", 32'(a_rdata), 32'(a_prev));
                  chk("b_rdata_hold", 32'(b_rdata), 32'(b_prev));
               end else begin
                  if (!t.we) b_prev = t.rdata;
                  chk("b_rdata", 32'(b_rdata), 32'(b_prev));
                  chk("a_rdata_hold", 32'(a_rdata), 32'(a_prev));
               end
            end
            ack_log.push_back(cyc);
         end
      end
   end

   // One cycle of requester-agent behaviour, applied at the falling edge.
   // On ack a requester with another command keeps req high and loads it.
   task automatic tick();
      txn_t t;
      @(negedge clk);
      if (a_req && a_ack) begin
         if (a_cmds.size() > 0) begin
            t = a_cmds.pop_front();
            a_we = t.we; a_addr = t.addr; a_wdata = t.wdata;
            a_elig = cyc + 2;
         end else a_req = 1'b0;
      end else if (!a_req && a_cmds.size() > 0) begin
         t = a_cmds.pop_front();
         a_we = t.we; a_addr = t.addr; a_wdata = t.wdata;
         a_req = 1'b1; a_elig = cyc;
      end
      if (b_req && b_ack) begin
         if (b_cmds.size() > 0) begin
            t = b_cmds.pop_front();
            b_we = t.we; b_addr = t.addr; b_wdata = t.wdata;
            b_elig = cyc + 2;
         end else b_req = 1'b0;
      end else if (!b_req && b_cmds.size() > 0) begin
         t = b_cmds.pop_front();
         b_we = t.we; b_addr = t.addr; b_wdata = t.wdata;
         b_req = 1'b1; b_elig = cyc;
      end
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((sb.size() > 0 || a_req || b_req || a_cmds.size() > 0 || b_cmds.size() > 0)
             && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) begin
         n_checks++; n_errors++;
         $display("FAIL drain_timeout actual=%0d_pending required=0 (cycle %0d)", sb.size(), cyc);
         sb.delete(); a_cmds.delete(); b_cmds.delete();
         a_req = 1'b0; b_req = 1'b0;
      end
      tick();
      tick();
   endtask

   initial begin
      int unsigned s0, k0, n0, ack_c;
      int          rd_cnt;
      logic        got;
      logic [15:0] got_data;
      logic [9:0]  rd_addr;

      rst = 1'b1;
      a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
      b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
      r3_a_req = 0; r3_a_we = 0; r3_a_addr = '0; r3_a_wdata = '0;
      r3_b_req = 0; r3_b_we = 0; r3_b_addr = '0; r3_b_wdata = '0;

      // Reset held with both requests high; A must win first afterwards.
      a_cmds.push_back(mk(0, 1, 10'd3, 16'h0F0F, 16'h0));
      b_cmds.push_back(mk(1, 1, 10'd4, 16'hF0F0, 16'h0));
      repeat (3) tick();
      rst = 1'b0;
      sb.push_back(mk(0, 1, 10'd3, 16'hF0F, 16'h0));
      sb.push_back(mk(1, 1, 10'd4, 16'hF0F0, 16'h0));
      drain(50);

      // A write then read, with exact timing.
      a_cmds.push_back(mk(0, 1, 10'd1, 16'hABCD, 16'h0));
      sb.push_back(mk(0, 1, 10'd1, 16'hABCD, 16'h0));
      drain(30);
      chk("wr_strobe_cyc", strobe_log[$], a_elig + 1);
      chk("wr_ack_cyc", ack_log[$], a_elig + 2);
      a_cmds.push_back(mk(0, 0, 10'd1, 16'h0, 16'hABCD));
      sb.push_back(mk(0, 0, 10'd1, 16'h0, 16'hABCD));
      drain(30);
      chk("rd_strobe_cyc", strobe_log[$], a_elig + 1);
      chk("rd_ack_cyc", ack_log[$], a_elig + 3);

      // Simultaneous requests from reset, then a second collision.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      a_cmds.push_back(mk(0, 1, 10'd5, 16'h1111, 16'h0));
      b_cmds.push_back(mk(1, 0, 10'd5, 16'h0, 16'h1111));
      sb.push_back(mk(0, 1, 10'd5, 16'h1111, 16'h0));
      sb.push_back(mk(1, 0, 10'd5, 16'h0, 16'h1111));
      drain(50);
      a_cmds.push_back(mk(0, 1, 10'd6, 16'h2222, 16'h0));
      b_cmds.push_back(mk(1, 1, 10'd6, 16'h3333, 16'h0));
      sb.push_back(mk(0, 1, 10'd6, 16'h2222, 16'h0));
      sb.push_back(mk(1, 1, 10'd6, 16'h3333, 16'h0));
      drain(50);

      // Fairness: both held high for 8 transactions.
      s0 = strobe_log.size();
      k0 = ack_log.size();
      for (int i = 0; i < 4; i++) begin
         a_cmds.push_back(mk(0, 1, 10'd8, 16'hA000 + 16'(i), 16'h0));
         b_cmds.push_back(mk(1, 0, 10'd8, 16'h0, 16'hA000 + 16'(i)));
         sb.push_back(mk(0, 1, 10'd8, 16'hA000 + 16'(i), 16'h0));
         sb.push_back(mk(1, 0, 10'd8, 16'h0, 16'hA000 + 16'(i)));
      end
      drain(200);
      chk("fair_count", strobe_log.size() - s0, 32'd8);
      chk("b2b_other_gap", strobe_log[s0 + 1], ack_log[k0] + 2);

      // A alone, held high: masked for one cycle after its ack.
      s0 = strobe_log.size();
      k0 = ack_log.size();
      a_cmds.push_back(mk(0, 1, 10'd9, 16'h7777, 16'h0));
      a_cmds.push_back(mk(0, 1, 10'd9, 16'h8888, 16'h0));
      sb.push_back(mk(0, 1, 10'd9, 16'h7777, 16'h0));
      sb.push_back(mk(0, 1, 10'd9, 16'h8888, 16'h0));
      drain(50);
      chk("mask_gap", strobe_log[s0 + 1], ack_log[k0] + 3);

      // Reset during the WAIT of a B read.
      b_cmds.push_back(mk(1, 0, 10'd5, 16'h0, 16'h1111));
      sb.push_back(mk(1, 0, 10'd5, 16'h0, 16'h1111));
      tick();
      tick();
      chk("mr_strobe", 32'(mem_read), 32'd1);
      tick();
      chk("mr_busy_wait", 32'(busy), 32'd1);
      chk("mr_no_ack", 32'(b_ack), 32'd0);
      rst = 1'b1;
      b_req = 1'b0;
      tick();
      chk("mr_busy_after", 32'(busy), 32'd0);
      chk("mr_no_ack2", 32'(b_ack), 32'd0);
      rst = 1'b0;
      repeat (4) begin
         tick();
         chk("mr_no_late_ack", 32'(b_ack), 32'd0);
      end
      b_cmds.push_back(mk(1, 0, 10'd5, 16'h0, 16'h1111));
      sb.push_back(mk(1, 0, 10'd5, 16'h0, 16'h1111));
      drain(30);
      chk("rereq_ack_cyc", ack_log[$], b_elig + 3);

      // RD_LAT = 3 instance: write then read address 1023.
      tick();
      r3_a_we = 1'b1; r3_a_addr = 10'd1023; r3_a_wdata = 16'hBEEF; r3_a_req = 1'b1;
      n0 = cyc; got = 1'b0; ack_c = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         tick();
         if (r3_a_ack) begin got = 1'b1; ack_c = cyc; r3_a_req = 1'b0; end
      end
      chk("r3_wr_ack_seen", 32'(got), 32'd1);
      chk("r3_wr_ack_cyc", ack_c, n0 + 2);
      tick();
      tick();
      r3_a_we = 1'b0; r3_a_wdata = '0; r3_a_req = 1'b1;
      n0 = cyc; got = 1'b0; ack_c = 0; rd_cnt = 0; got_data = '0; rd_addr = '0;
      for (int i = 0; i < 20 && !got; i++) begin
         tick();
         if (r3_mem_read) begin rd_cnt++; rd_addr = r3_mem_add; end
         if (r3_a_ack) begin
            got = 1'b1; ack_c = cyc; got_data = r3_a_rdata; r3_a_req = 1'b0;
         end
      end
      repeat (3) begin
         tick();
         if (r3_mem_read) rd_cnt++;
      end
      chk("r3_rd_ack_seen", 32'(got), 32'd1);
      chk("r3_rd_ack_cyc", ack_c, n0 + 5);
      chk("r3_rd_data", 32'(got_data), 32'hBEEF);
      chk("r3_rd_addr", 32'(rd_addr), 32'd1023);
      chk("r3_rd_strobes", 32'(rd_cnt), 32'd1);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Round-robin arbiter that shares one single-port block RAM (10-bit address, 16-bit data, registered read) between two independent requesters, A and B. Each requester issues single-word read or write transactions through a req/ack handshake. The arbiter serializes the transactions, drives the RAM's clk/add/write/read/din pins, and returns read data.

## Interface
- AW, 10: address width; matches the RAM `add` port.
- DW, 16: data width; matches the RAM `din`/`dout` ports.
- RD_LAT, 1: number of cycles from the `read` strobe cycle to valid `dout`. Legal range is 1..3.

Ports:
- clk  in  1  sole clock; all logic samples on the rising edge.
- rst  in  1  synchronous, active-high reset.
- a_req  in  1  requester A transaction request. Held high until `a_ack`.
- a_we  in  1  A: 1 = write, 0 = read. Must be stable while `a_req` is high.
- a_addr  in  AW  A word address. Must be stable while `a_req` is high.
- a_wdata  in  DW  A write data. Must be stable while `a_req` is high.
- a_ack  out  1  one-cycle completion pulse to A.
- a_rdata  out  DW  A read data. Valid in the `a_ack` cycle of a read; holds until the next A read ack.
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata: identical to the A ports, for requester B.
- mem_add  out  AW  to the RAM `add` pin.
- mem_write  out  1  to the RAM `write` pin. One-cycle strobe.
- mem_read  out  1  to the RAM `read` pin. One-cycle strobe.
- mem_din  out  DW  to the RAM `din` pin.
- mem_dout  in  DW  from the RAM `dout` pin.
- busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states are IDLE, ISSUE, WAIT and ACK. Only one transaction is in flight at a time.
- **IDLE**
  - Evaluates the eligible requests (see masking below).
  - If none are eligible, it stays in IDLE.
  - Otherwise it picks a winner and, at the clock edge, registers `mem_add`, `mem_din`, and exactly one of `mem_write`/`mem_read` (selected by the winner's `we`). Next state is ISSUE.
- **ISSUE**
  - The strobe is high for exactly this cycle and clears at the end of it.
  - A write goes to ACK.
  - A read goes to WAIT when RD_LAT ≥ 1.
- **WAIT**
  - Counts RD_LAT cycles.
  - At the end of the last WAIT cycle, `mem_dout` is captured into the winner's rdata register.
  - Next state is ACK.
- **ACK**
  - The winner's ack is high for one cycle. Next state is IDLE.
  - The winner's rdata updates only on reads; the loser's rdata never changes.
- **Arbitration**
  - A one-bit round-robin pointer selects which requester has priority. After reset it favours A.
  - If only one request is eligible, that requester wins regardless of the pointer.
  - If both are eligible, the favoured requester wins.
  - The pointer flips to the other requester at every ACK, so that requester gets priority next.
- **Masking**
  - In the IDLE cycle immediately after an ACK, the requester just served is ignored. This is the cycle in which it drops its req.
  - A requester holding req high beyond that cycle starts a new transaction.
- **Hold values**
  - `mem_add` and `mem_din` hold their last value between transactions.
  - `mem_write` and `mem_read` are 0 outside ISSUE.
  - Requests are never dropped. A pending request waits, keeping its inputs stable, until it is granted.
- **Reset**
  - Reset values: state = IDLE, pointer = A, all outputs = 0 (`busy`, acks, strobes, `mem_add`, `mem_din`, both rdata).
  - Reset asserted mid-transaction aborts the transaction at the next edge and no ack is issued.
  - A strobe already driven in the reset cycle completes at the RAM. The requester must re-request after reset.

## Timing
- Reference point: an eligible request is seen in IDLE at cycle N.
- Write:
  - `mem_write` is high in cycle N+1.
  - Ack is in cycle N+2.
  - Total latency is 2 cycles.
- Read:
  - `mem_read` is high in cycle N+1.
  - `mem_dout` is valid from cycle N+1+RD_LAT and is captured at the end of that cycle.
  - Ack and rdata are in cycle N+2+RD_LAT, i.e. N+3 with the default RD_LAT = 1.
- Back-to-back transactions: the next IDLE evaluation is in cycle ack+1. Peak throughput is one write every 3 cycles, or one read every 3+RD_LAT cycles.
- `busy` is high from N+1 through the ack cycle inclusive.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Reset:** hold `rst` for 3 cycles with both reqs high. All outputs read 0 and no strobe is issued. After release, A wins first.
- **A write then read:**
  - A writes 16'hABCD to address 1: `mem_write` is high at N+1 with `mem_add` = 1 and `mem_din` = 16'hABCD; `a_ack` pulses at N+2.
  - A then reads address 1: `mem_read` is high at N+1; `a_ack` pulses at N+3 with `a_rdata` = 16'hABCD.
- **Simultaneous requests:**
  - From reset, A writes 16'h1111 to address 5 and B reads address 5, both requests asserted in the same cycle.
  - A is served first; B's read follows and returns 16'h1111 on `b_rdata`.
  - The pointer now favours A, so a new A+B collision is won by A.
- **Fairness:** both reqs are held high continuously for 8 transactions. Grants alternate A, B, A, B…, with the served requester masked for one cycle after each ack. `b_rdata` does not change on A acks.
- **Reset mid-read:**
  - Assert `rst` during WAIT of a B read. No `b_ack` occurs and `busy` = 0 the next cycle.
  - After reset, a B re-request completes normally.
- **RD_LAT = 3:** a read to address 1023 (wrap-boundary address) with a RAM model of 3-cycle latency. Ack arrives at N+5 with the correct data; `mem_read` is high for exactly one cycle.
